pc_sequencer: RTL and testbench

- Fetch/execute sequencer and program-counter stage for the multicycle datapath.
- Owns the fetch/execute state flip-flop, the PC, the instruction register and a small return-address stack.
- Consumes PS, IL and a call strobe from control decode. Supplies the state bit and the IR opcode/offset fields back to decode.
- Supplies the PC to the memory address mux.

---
 rtl/pc_sequencer.sv | 146 ++++++++++++++
 tb/tb_pc_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer: owns the state bit, PC, IR and a small return-address stack.
// Latency: every output is registered and updates on the clock edge after its inputs are sampled.
// Backpressure: stall=1 freezes every register. There is no other flow control.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   stall                 freeze all state
//   PS[1:0]               PC select: 00 hold, 01 +1, 10 +sext(offset), 11 pop return address
//   IL                    load ir from instr_in
//   call                  push pc+1 onto the return stack
//   offset[OFF_W-1:0]     signed branch/jump displacement
//   instr_in              instruction word from memory
//   state                 0 = fetch, 1 = execute
//   pc, ir                current program counter and instruction register
//   sp                    number of valid stack entries (0..DEPTH)
//   overflow, underflow   sticky stack error flags, cleared only by reset
module pc_sequencer #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned OFF_W    = 6,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic [1:0]                 PS,
  input  logic                       IL,
  input  logic                       call,
  input  logic [OFF_W-1:0]           offset,
  input  logic [INSTR_W-1:0]         instr_in,
  output logic                       state,
  output logic [ADDR_W-1:0]          pc,
  output logic [INSTR_W-1:0]         ir,
  output logic [$clog2(DEPTH):0]     sp,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned SP_W  = IDX_W + 1;

  typedef enum logic {
    FETCH   = 1'b0,
    EXECUTE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [ADDR_W-1:0]   stack_q [DEPTH];
  logic [ADDR_W-1:0]   stack_d [DEPTH];

  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   off_ext;
  logic [IDX_W-1:0]    push_idx;
  logic [IDX_W-1:0]    pop_idx;
  logic                stk_empty;
  logic                stk_full;

  assign pc_inc    = pc_q + ADDR_W'(1);
  assign off_ext   = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
  // Low bits of sp address the next free slot; only used when sp<DEPTH.
  assign push_idx  = sp_q[IDX_W-1:0];
  // Top-of-stack slot. When sp==DEPTH the low bits are zero and this wraps to DEPTH-1.
  assign pop_idx   = push_idx - IDX_W'(1);
  assign stk_empty = (sp_q == '0);
  assign stk_full  = (sp_q == SP_W'(DEPTH));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    stack_d = stack_q;

    if (!stall) begin
      state_d = (state_q == FETCH) ? EXECUTE : FETCH;

      if (IL) begin
        ir_d = instr_in;
      end

      case (PS)
        2'b01:   pc_d = pc_inc;
        2'b10:   pc_d = pc_q + off_ext;
        2'b11:   if (!stk_empty) pc_d = stack_q[pop_idx];
        default: pc_d = pc_q;
      endcase

      if ((PS == 2'b11) && call && !stk_empty) begin
        // Return and call together: swap the top entry in place, depth unchanged.
        stack_d[pop_idx] = pc_inc;
      end else begin
        if (PS == 2'b11) begin
          if (stk_empty) unf_d = 1'b1;
          else           sp_d  = sp_q - SP_W'(1);
        end
        // Pop above cannot coincide with a push here, so sp_q is still the depth seen by the push.
        if (call) begin
          if (stk_full) begin
            ovf_d = 1'b1;
          end else begin
            stack_d[push_idx] = pc_inc;
            sp_d              = sp_q + SP_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= ADDR_W'(RESET_PC);
      ir_q    <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      stack_q <= stack_d;
    end
  end

  assign state     = state_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign sp        = sp_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  PS;
  logic        IL;
  logic        call;
  logic [5:0]  offset;
  logic [15:0] instr_in;
  logic        state;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [2:0]  sp;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;
  logic exp_state = 1'b0;

  pc_sequencer #(
    .ADDR_W(8), .INSTR_W(16), .OFF_W(6), .DEPTH(4), .RESET_PC(0)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .PS(PS), .IL(IL), .call(call),
    .offset(offset), .instr_in(instr_in), .state(state), .pc(pc), .ir(ir),
    .sp(sp), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one edge, sample 1 time unit later and check the state bit.
  task automatic step(input logic [1:0] ps_v, input logic il_v, input logic call_v,
                      input logic [5:0] off_v, input logic [15:0] ins_v);
    PS = ps_v; IL = il_v; call = call_v; offset = off_v; instr_in = ins_v;
    @(posedge clk);
    #1;
    if (!stall) exp_state = ~exp_state;
    chk("state", {31'd0, state}, {31'd0, exp_state});
  endtask

  task automatic chk_pc_sp(input string tag, input logic [7:0] epc, input logic [2:0] esp);
    chk({tag, "_pc"}, {24'd0, pc}, {24'd0, epc});
    chk({tag, "_sp"}, {29'd0, sp}, {29'd0, esp});
  endtask

  task automatic chk_flags(input string tag, input logic eo, input logic eu);
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
    chk({tag, "_unf"}, {31'd0, underflow}, {31'd0, eu});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; PS = 2'b00; IL = 1'b0; call = 1'b0;
    offset = '0; instr_in = '0;
    #12;
    chk("rst_state", {31'd0, state}, 32'd0);
    chk_pc_sp("rst", 8'h00, 3'd0);
    chk("rst_ir", {16'd0, ir}, 32'd0);
    chk_flags("rst", 1'b0, 1'b0);
    reset = 1'b0;
    exp_state = 1'b0;

    // Build up some state, then reset in the middle of a cycle.
    step(2'b10, 1'b1, 1'b1, 6'b011111, 16'h1234);
    chk_pc_sp("pre1", 8'h1F, 3'd1);
    chk("pre1_ir", {16'd0, ir}, 32'h1234);
    step(2'b10, 1'b0, 1'b0, 6'b000100, 16'h0000);
    chk("pre2_pc", {24'd0, pc}, 32'h23);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_state", {31'd0, state}, 32'd0);
    chk_pc_sp("mid_rst", 8'h00, 3'd0);
    chk("mid_rst_ir", {16'd0, ir}, 32'd0);
    #3;
    reset = 1'b0;
    exp_state = 1'b0;

    // State toggles 0->1->0->1->0 on successive edges.
    for (int i = 0; i < 4; i++) step(2'b00, 1'b0, 1'b0, 6'd0, 16'h0);

    // IR load and increment.
    step(2'b00, 1'b1, 1'b0, 6'd0, 16'h9A05);
    chk("il_ir", {16'd0, ir}, 32'h9A05);
    chk("il_pc", {24'd0, pc}, 32'h00);
    step(2'b01, 1'b0, 1'b0, 6'd0, 16'hBEEF);
    chk("inc_pc", {24'd0, pc}, 32'h01);
    chk("ir_hold", {16'd0, ir}, 32'h9A05);
    step(2'b10, 1'b0, 1'b0, 6'b111110, 16'h0);   // 0x01 - 2
    chk("to_ff", {24'd0, pc}, 32'hFF);
    step(2'b01, 1'b0, 1'b0, 6'd0, 16'h0);
    chk("wrap_inc", {24'd0, pc}, 32'h00);

    // Offset jumps.
    step(2'b10, 1'b0, 1'b0, 6'b010000, 16'h0);   // +16
    chk("to_10", {24'd0, pc}, 32'h10);
    step(2'b10, 1'b0, 1'b0, 6'b111100, 16'h0);   // -4
    chk("neg4", {24'd0, pc}, 32'h0C);
    step(2'b10, 1'b0, 1'b0, 6'b110110, 16'h0);   // -10
    chk("to_02", {24'd0, pc}, 32'h02);
    step(2'b10, 1'b0, 1'b0, 6'b111100, 16'h0);   // -4 wraps
    chk("neg_wrap", {24'd0, pc}, 32'hFE);
    step(2'b10, 1'b0, 1'b0, 6'b010010, 16'h0);   // +18
    chk("pos_wrap", {24'd0, pc}, 32'h10);
    step(2'b10, 1'b0, 1'b0, 6'b011111, 16'h0);   // +31
    chk("pos31", {24'd0, pc}, 32'h2F);

    // Call with jump, then return.
    step(2'b10, 1'b0, 1'b0, 6'b110001, 16'h0);   // -15
    chk("to_20", {24'd0, pc}, 32'h20);
    step(2'b10, 1'b0, 1'b1, 6'b001000, 16'h0);   // call, +8
    chk_pc_sp("call", 8'h28, 3'd1);
    step(2'b01, 1'b0, 1'b0, 6'd0, 16'h0);
    chk("after_call", {24'd0, pc}, 32'h29);
    step(2'b11, 1'b0, 1'b0, 6'd0, 16'h0);
    chk_pc_sp("ret", 8'h21, 3'd0);
    chk_flags("ret", 1'b0, 1'b0);

    // Fill the stack, then one more push.
    step(2'b01, 1'b0, 1'b1, 6'd0, 16'h0); chk_pc_sp("push1", 8'h22, 3'd1);
    step(2'b01, 1'b0, 1'b1, 6'd0, 16'h0); chk_pc_sp("push2", 8'h23, 3'd2);
    step(2'b01, 1'b0, 1'b1, 6'd0, 16'h0); chk_pc_sp("push3", 8'h24, 3'd3);
    step(2'b01, 1'b0, 1'b1, 6'd0, 16'h0); chk_pc_sp("push4", 8'h25, 3'd4);
    chk_flags("full", 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b1, 6'd0, 16'h0); chk_pc_sp("push5", 8'h26, 3'd4);
    chk_flags("ovf", 1'b1, 1'b0);

    // Drain in LIFO order, then one more pop.
    step(2'b11, 1'b0, 1'b0, 6'd0, 16'h0); chk_pc_sp("pop1", 8'h25, 3'd3);
    step(2'b11, 1'b0, 1'b0, 6'd0, 16'h0); chk_pc_sp("pop2", 8'h24, 3'd2);
    step(2'b11, 1'b0, 1'b0, 6'd0, 16'h0); chk_pc_sp("pop3", 8'h23, 3'd1);
    step(2'b11, 1'b0, 1'b0, 6'd0, 16'h0); chk_pc_sp("pop4", 8'h22, 3'd0);
    chk_flags("empty", 1'b1, 1'b0);
    step(2'b11, 1'b0, 1'b0, 6'd0, 16'h0); chk_pc_sp("pop5", 8'h22, 3'd0);
    chk_flags("unf", 1'b1, 1'b1);
    step(2'b00, 1'b0, 1'b0, 6'd0, 16'h0);
    step(2'b01, 1'b0, 1'b0, 6'd0, 16'h0);
    chk_flags("sticky", 1'b1, 1'b1);
    chk("sticky_pc", {24'd0, pc}, 32'h23);

    // Stall freezes everything, including the state bit.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(2'b01, 1'b1, 1'b1, 6'd0, 16'hFFFF);
      chk_pc_sp("stall", 8'h23, 3'd0);
      chk("stall_ir", {16'd0, ir}, 32'h9A05);
    end
    stall = 1'b0;

    // Build sp=2 with top=0x40 and pc=0x50.
    step(2'b00, 1'b0, 1'b1, 6'd0, 16'h0);       // push 0x24
    chk_pc_sp("setup1", 8'h23, 3'd1);
    step(2'b10, 1'b0, 1'b0, 6'b011100, 16'h0);  // +28 -> 0x3F
    chk("setup2", {24'd0, pc}, 32'h3F);
    step(2'b10, 1'b0, 1'b1, 6'b010001, 16'h0);  // push 0x40, +17 -> 0x50
    chk_pc_sp("setup3", 8'h50, 3'd2);
    step(2'b11, 1'b0, 1'b1, 6'd0, 16'h0);       // return + call together
    chk_pc_sp("swap", 8'h40, 3'd2);
    chk_flags("swap", 1'b1, 1'b1);
    step(2'b11, 1'b0, 1'b0, 6'd0, 16'h0);
    chk_pc_sp("swap_top", 8'h51, 3'd1);
    step(2'b11, 1'b0, 1'b0, 6'd0, 16'h0);
    chk_pc_sp("swap_bot", 8'h24, 3'd0);

    // Return + call on an empty stack: pop underflows, push lands in slot 0.
    step(2'b11, 1'b0, 1'b1, 6'd0, 16'h0);
    chk_pc_sp("empty_swap", 8'h24, 3'd1);
    step(2'b11, 1'b0, 1'b0, 6'd0, 16'h0);
    chk_pc_sp("empty_swap_pop", 8'h25, 3'd0);

    // Only reset clears the flags.
    #2;
    reset = 1'b1;
    #1;
    chk_flags("final_rst", 1'b0, 1'b0);
    chk_pc_sp("final_rst", 8'h00, 3'd0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
